// File: rtl/ex_flag_stage.sv
// rtl/ex_flag_stage.sv - execute stage: 16-bit ALU, carry/zero flag registers, flag bypass, EX/MEM register
module ex_flag_stage #(
   parameter int WIDTH = 16,
   parameter int RW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [15:0]      instr,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [1:0]       alu_op,
   input  logic             carry_we,
   input  logic             zero_we,
   input  logic             reg_we,
   input  logic [RW-1:0]    dest,
   input  logic             stall,
   input  logic             flush,
   output logic             carry_fwd,
   output logic             zero_fwd,
   output logic             carry_q,
   output logic             zero_q,
   output logic             out_valid,
   output logic             out_reg_we,
   output logic [WIDTH-1:0] out_result,
   output logic [RW-1:0]    out_dest
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_NAND = 2'b01;
   localparam logic [1:0] OP_PASS = 2'b10;
   localparam logic [1:0] OP_SUB  = 2'b11;

   logic             is_adl;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] result;
   logic             new_carry;
   logic             new_zero;
   logic             live;
   logic             bypass_ok;

   logic             carry_d;
   logic             zero_d;
   logic             out_valid_d, out_valid_q;
   logic             out_reg_we_d, out_reg_we_q;
   logic [WIDTH-1:0] out_result_d, out_result_q;
   logic [RW-1:0]    out_dest_d, out_dest_q;

   // Only the opcode and the ADL function bits of the instruction matter here.
   logic             unused_instr_bits;
   assign unused_instr_bits = ^instr[11:2];

   // ALU datapath: effective B (ADL shifts B left by one), result and new flags.
   always_comb begin
      is_adl    = (instr[15:12] == 4'b0001) && (instr[1:0] == 2'b11);
      b_eff     = is_adl ? {op_b[WIDTH-2:0], 1'b0} : op_b;
      sum       = {1'b0, op_a} + {1'b0, b_eff};
      diff      = {1'b0, op_a} - {1'b0, b_eff};
      result    = '0;
      new_carry = 1'b0;
      case (alu_op)
         OP_ADD: begin
            result    = sum[WIDTH-1:0];
            new_carry = sum[WIDTH];
         end
         OP_NAND: begin
            result    = ~(op_a & b_eff);
            new_carry = 1'b0;
         end
         OP_PASS: begin
            result    = op_b;
            new_carry = 1'b0;
         end
         OP_SUB: begin
            result    = diff[WIDTH-1:0];
            new_carry = diff[WIDTH];
         end
         default: begin
            result    = '0;
            new_carry = 1'b0;
         end
      endcase
      new_zero = (result == '0);
   end

   // Stall does not gate the bypass: a stalled consumer in ID re-reads every cycle.
   assign live      = in_valid & ~stall & ~flush;
   assign bypass_ok = in_valid & ~flush;
   assign carry_fwd = (bypass_ok & carry_we) ? new_carry : carry_q;
   assign zero_fwd  = (bypass_ok & zero_we)  ? new_zero  : zero_q;

   // Next-state for flags and the EX/MEM register; stall holds everything.
   always_comb begin
      carry_d      = carry_q;
      zero_d       = zero_q;
      out_valid_d  = out_valid_q;
      out_reg_we_d = out_reg_we_q;
      out_result_d = out_result_q;
      out_dest_d   = out_dest_q;
      if (live && carry_we) carry_d = new_carry;
      if (live && zero_we)  zero_d  = new_zero;
      if (!stall) begin
         if (flush || !in_valid) begin
            out_valid_d  = 1'b0;
            out_reg_we_d = 1'b0;
         end else begin
            out_valid_d  = 1'b1;
            out_reg_we_d = reg_we;
            out_result_d = result;
            out_dest_d   = dest;
         end
      end
   end

   // State registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_reg_we_q <= 1'b0;
         out_result_q <= '0;
         out_dest_q   <= '0;
      end else begin
         carry_q      <= carry_d;
         zero_q       <= zero_d;
         out_valid_q  <= out_valid_d;
         out_reg_we_q <= out_reg_we_d;
         out_result_q <= out_result_d;
         out_dest_q   <= out_dest_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_reg_we = out_reg_we_q;
   assign out_result = out_result_q;
   assign out_dest   = out_dest_q;

endmodule
